// File: rtl/key_voice_tracker_if.sv
// Report-input and note-event handshake bundle for key_voice_tracker.
// The master side drives reports and evt_ready; the slave side (the tracker) drives note events.
interface key_voice_tracker_if #(
    parameter int NUM_SLOTS  = 6,
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 4
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [8*NUM_SLOTS-1:0] keycode_in;
    logic                   report_valid;
    logic                   evt_valid;
    logic                   evt_ready;
    logic                   evt_on;
    logic [VW-1:0]          evt_voice;
    logic [NOTE_W-1:0]      evt_note;

    modport master (
        output keycode_in, report_valid, evt_ready,
        input  evt_valid, evt_on, evt_voice, evt_note
    );

    modport slave (
        input  keycode_in, report_valid, evt_ready,
        output evt_valid, evt_on, evt_voice, evt_note
    );
endinterface

// File: rtl/key_voice_tracker.sv
// Turns HID keyboard reports into note-on/off events over a small voice table.
// Optional octave keys (codes 29/27) are enabled with the KEY_OCTAVE_EN macro.
module key_voice_tracker #(
    parameter int NUM_SLOTS  = 6,
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    key_voice_tracker_if.slave           bus,
    output logic [NUM_VOICES-1:0]        o_voice_active,
    output logic [NOTE_W*NUM_VOICES-1:0] o_voice_note,
    output logic [11:0]                  o_highlight,
    output logic                         o_busy,
    output logic [7:0]                   o_dropped_cnt,
    output logic [2:0]                   o_octave
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [2:0] {IDLE, REL_SCAN, PRS_SCAN, EMIT_OFF, EMIT_ON} state_t;

    function automatic logic [NOTE_W-1:0] map_note(input logic [7:0] code);
        case (code)
            8'd43:   map_note = NOTE_W'(1);
            8'd20:   map_note = NOTE_W'(2);
            8'd26:   map_note = NOTE_W'(3);
            8'd8:    map_note = NOTE_W'(4);
            8'd21:   map_note = NOTE_W'(5);
            8'd23:   map_note = NOTE_W'(6);
            8'd28:   map_note = NOTE_W'(7);
            8'd24:   map_note = NOTE_W'(8);
            8'd12:   map_note = NOTE_W'(9);
            8'd18:   map_note = NOTE_W'(10);
            8'd19:   map_note = NOTE_W'(11);
            8'd47:   map_note = NOTE_W'(12);
            default: map_note = '0;
        endcase
    endfunction

    function automatic logic [11:0] note_mask(input logic [NOTE_W-1:0] note);
        note_mask = '0;
        for (int n = 1; n <= 12; n++) begin
            if (note == NOTE_W'(n)) note_mask[n-1] = 1'b1;
        end
    endfunction

    state_t                 r_state;
    logic [8*NUM_SLOTS-1:0] r_pending;
    logic                   r_pend_vld;
    logic [8*NUM_SLOTS-1:0] r_work;
    logic [VW-1:0]          r_vidx;
    logic [SW-1:0]          r_sidx;
    logic [NUM_VOICES-1:0]  r_active;
    logic [NOTE_W-1:0]      r_vnote [NUM_VOICES];
    logic [11:0]            r_highlight;
    logic [7:0]             r_dropped;
    logic                   r_evt_valid;
    logic                   r_evt_on;
    logic [VW-1:0]          r_evt_voice;
    logic [NOTE_W-1:0]      r_evt_note;
`ifdef KEY_OCTAVE_EN
    logic [2:0]             r_octave;
    logic                   r_prev_up, r_prev_dn, r_cur_up, r_cur_dn;
    logic                   w_up_seen, w_dn_seen;
`endif

    logic [7:0]        w_codes [NUM_SLOTS];
    logic [7:0]        w_slot_code;
    logic [NOTE_W-1:0] w_slot_note;
    logic [NOTE_W-1:0] w_vnote_cur;
    logic              w_rel_present;
    logic              w_dup;
    logic              w_held;
    logic              w_want_on;
    logic              w_free_found;
    logic [VW-1:0]     w_free_idx;
    logic              w_last_voice;
    logic              w_last_slot;

    // A slot's note is wanted only on its first appearance and only if no voice already holds it.
    always_comb begin
        for (int s = 0; s < NUM_SLOTS; s++) w_codes[s] = r_work[8*s +: 8];
        w_slot_code   = w_codes[r_sidx];
        w_slot_note   = map_note(w_slot_code);
        w_vnote_cur   = r_vnote[r_vidx];
        w_rel_present = 1'b0;
        w_dup         = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (map_note(w_codes[s]) == w_vnote_cur) w_rel_present = 1'b1;
            if (SW'(s) < r_sidx && map_note(w_codes[s]) == w_slot_note) w_dup = 1'b1;
        end
        w_held       = |(r_highlight & note_mask(w_slot_note));
        w_want_on    = (w_slot_note != '0) && !w_dup && !w_held;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!r_active[v]) begin
                w_free_found = 1'b1;
                w_free_idx   = VW'(v);
            end
        end
        w_last_voice = (r_vidx == VW'(NUM_VOICES - 1));
        w_last_slot  = (r_sidx == SW'(NUM_SLOTS - 1));
    end

`ifdef KEY_OCTAVE_EN
    assign w_up_seen = r_cur_up | (w_slot_code == 8'd27);
    assign w_dn_seen = r_cur_dn | (w_slot_code == 8'd29);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_pend_vld  <= 1'b0;
            r_work      <= '0;
            r_vidx      <= '0;
            r_sidx      <= '0;
            r_active    <= '0;
            for (int v = 0; v < NUM_VOICES; v++) r_vnote[v] <= '0;
            r_highlight <= '0;
            r_dropped   <= '0;
            r_evt_valid <= 1'b0;
            r_evt_on    <= 1'b0;
            r_evt_voice <= '0;
            r_evt_note  <= '0;
`ifdef KEY_OCTAVE_EN
            r_octave    <= 3'd4;
            r_prev_up   <= 1'b0;
            r_prev_dn   <= 1'b0;
            r_cur_up    <= 1'b0;
            r_cur_dn    <= 1'b0;
`endif
        end else begin
            // A fresh report always wins over a consumption in the same cycle.
            if (bus.report_valid) begin
                r_pending  <= bus.keycode_in;
                r_pend_vld <= 1'b1;
            end else if (r_state == IDLE && r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (r_pend_vld) begin
                        r_work  <= r_pending;
                        r_vidx  <= '0;
                        r_state <= REL_SCAN;
`ifdef KEY_OCTAVE_EN
                        r_cur_up <= 1'b0;
                        r_cur_dn <= 1'b0;
`endif
                    end
                end
                REL_SCAN: begin
                    if (r_active[r_vidx] && !w_rel_present) begin
                        r_evt_valid <= 1'b1;
                        r_evt_on    <= 1'b0;
                        r_evt_voice <= r_vidx;
                        r_evt_note  <= w_vnote_cur;
                        r_state     <= EMIT_OFF;
                    end else if (w_last_voice) begin
                        r_sidx  <= '0;
                        r_state <= PRS_SCAN;
                    end else begin
                        r_vidx <= r_vidx + VW'(1);
                    end
                end
                EMIT_OFF: begin
                    if (bus.evt_ready) begin
                        r_evt_valid           <= 1'b0;
                        r_active[r_evt_voice] <= 1'b0;
                        r_vnote[r_evt_voice]  <= '0;
                        r_highlight           <= r_highlight & ~note_mask(r_evt_note);
                        if (w_last_voice) begin
                            r_sidx  <= '0;
                            r_state <= PRS_SCAN;
                        end else begin
                            r_vidx  <= r_vidx + VW'(1);
                            r_state <= REL_SCAN;
                        end
                    end
                end
                PRS_SCAN: begin
`ifdef KEY_OCTAVE_EN
                    // Octave keys step only on the first report in which they appear.
                    if (w_slot_code == 8'd27) begin
                        if (!r_prev_up && !r_cur_up && r_octave != 3'd7) r_octave <= r_octave + 3'd1;
                        r_cur_up <= 1'b1;
                    end
                    if (w_slot_code == 8'd29) begin
                        if (!r_prev_dn && !r_cur_dn && r_octave != 3'd0) r_octave <= r_octave - 3'd1;
                        r_cur_dn <= 1'b1;
                    end
`endif
                    if (w_want_on && w_free_found) begin
                        r_evt_valid <= 1'b1;
                        r_evt_on    <= 1'b1;
                        r_evt_voice <= w_free_idx;
                        r_evt_note  <= w_slot_note;
                        r_state     <= EMIT_ON;
                    end else begin
                        if (w_want_on && r_dropped != 8'hFF) r_dropped <= r_dropped + 8'd1;
                        if (w_last_slot) begin
                            r_state <= IDLE;
`ifdef KEY_OCTAVE_EN
                            r_prev_up <= w_up_seen;
                            r_prev_dn <= w_dn_seen;
`endif
                        end else begin
                            r_sidx <= r_sidx + SW'(1);
                        end
                    end
                end
                EMIT_ON: begin
                    if (bus.evt_ready) begin
                        r_evt_valid           <= 1'b0;
                        r_active[r_evt_voice] <= 1'b1;
                        r_vnote[r_evt_voice]  <= r_evt_note;
                        r_highlight           <= r_highlight | note_mask(r_evt_note);
                        if (w_last_slot) begin
                            r_state <= IDLE;
`ifdef KEY_OCTAVE_EN
                            r_prev_up <= w_up_seen;
                            r_prev_dn <= w_dn_seen;
`endif
                        end else begin
                            r_sidx  <= r_sidx + SW'(1);
                            r_state <= PRS_SCAN;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_voice_note = '0;
        for (int v = 0; v < NUM_VOICES; v++) o_voice_note[NOTE_W*v +: NOTE_W] = r_vnote[v];
    end

    assign o_voice_active = r_active;
    assign o_highlight    = r_highlight;
    assign o_busy         = (r_state != IDLE);
    assign o_dropped_cnt  = r_dropped;
`ifdef KEY_OCTAVE_EN
    assign o_octave       = r_octave;
`else
    assign o_octave       = 3'd4;
`endif

    assign bus.evt_valid = r_evt_valid;
    assign bus.evt_on    = r_evt_on;
    assign bus.evt_voice = r_evt_voice;
    assign bus.evt_note  = r_evt_note;
endmodule

// File: doc/key_voice_tracker.md
KEY_VOICE_TRACKER -- requirements
Module: key_voice_tracker

Interface
REQ-001 Parameters, one per line: NUM_SLOTS, default 6, keycode slots per HID report; NUM_VOICES, default 4, voice table entries; NOTE_W, default 4, note index width.
REQ-002 Clk  input  1  system clock; all state on rising edge.
REQ-003 Reset_n  input  1  asynchronous active-low reset.
REQ-004 keycode_in  input  8*NUM_SLOTS  HID keycodes, slot k at bits [8k+7:8k]; 0 = empty slot.
REQ-005 report_valid  input  1  one-cycle strobe; keycode_in valid this cycle.
REQ-006 evt_valid  output  1  note event available.
REQ-007 evt_ready  input  1  consumer accepts event when evt_valid & evt_ready.
REQ-008 evt_on  output  1  1 = note-on, 0 = note-off.
REQ-009 evt_voice  output  clog2(NUM_VOICES)  voice index of event.
REQ-010 evt_note  output  NOTE_W  note index 1..12 of event.
REQ-011 voice_active  output  NUM_VOICES  per-voice held flag.
REQ-012 voice_note  output  NOTE_W*NUM_VOICES  note of voice v at [NOTE_W*v +: NOTE_W]; 0 when inactive.
REQ-013 highlight  output  12  bit n-1 set iff note n is held by some voice.
REQ-014 busy  output  1  high whenever FSM not in IDLE.
REQ-015 dropped_cnt  output  8  count of note-ons lost for lack of a free voice; saturates at 255.
REQ-016 octave  output  3  current octave.

Function
REQ-017 Keycode map: 43->1, 20->2, 26->3, 8->4, 21->5, 23->6, 28->7, 24->8, 12->9, 18->10, 19->11, 47->12; all other codes unmapped (ignored).
REQ-018 report_valid captures keycode_in into pending register; a later report before consumption overwrites it (latest wins); pending never lost on busy.
REQ-019 FSM states IDLE, REL_SCAN, PRS_SCAN, EMIT_OFF, EMIT_ON.
REQ-020 IDLE: if pending present, copy to working report, clear pending, go REL_SCAN with voice index 0 next cycle.
REQ-021 REL_SCAN: one voice per cycle, ascending; active voice whose note is absent from working report -> EMIT_OFF; after last voice -> PRS_SCAN slot 0.
REQ-022 EMIT_OFF: hold evt_valid=1, evt_on=0; on handshake clear voice (active=0, note=0) same edge, resume REL_SCAN at next voice.
REQ-023 PRS_SCAN: one slot per cycle, ascending; mapped note not held by any voice -> allocate lowest-index free voice, go EMIT_ON; held or unmapped -> skip; duplicate note in later slot skipped; after last slot -> IDLE.
REQ-024 No free voice: no event, dropped_cnt +1 (saturating), continue scan.
REQ-025 EMIT_ON: evt_valid=1, evt_on=1; voice set active with note on handshake edge; resume PRS_SCAN at next slot.
REQ-026 evt_* outputs stable while evt_valid=1 and evt_ready=0; evt_valid deasserts the cycle after handshake.
REQ-027 All note-offs of a report precede its note-ons.
REQ-028 highlight, voice_active, voice_note are registered state, updated on handshake edges only.

Reset
REQ-029 Reset_n low: FSM IDLE, pending cleared, all voices inactive, voice_note=0, highlight=0, evt_valid=0, busy=0, dropped_cnt=0, octave=4, regardless of handshake in progress.
REQ-030 Reset_n low mid-event drops the event; no replay after release.

Configuration
REQ-031 Macro KEY_OCTAVE_EN defined: keycode 29 decrements, 27 increments octave once per report in which it newly appears, clamped 0..7; evaluated during PRS_SCAN, produces no event.
REQ-032 KEY_OCTAVE_EN undefined: octave constant 4; codes 29 and 27 unmapped.

Verification
REQ-033 Report {20} -> one event on=1 voice 0 note 2; highlight=12'h002.
REQ-034 Then report {20,26} -> single event on=1 voice 1 note 3; no repeat for note 2.
REQ-035 Then report {0} -> off voice 0 note 2, then off voice 1 note 3; highlight=0.
REQ-036 NUM_VOICES=4, report {43,20,26,8,21} -> four note-ons voices 0..3, dropped_cnt=1.
REQ-037 evt_ready held 0 for 10 cycles with second report arriving -> event held stable; second report processed after first completes.
REQ-038 KEY_OCTAVE_EN: reports {27},{0},{27} -> octave 6; Reset_n pulse mid-EMIT_ON -> all outputs at reset values, octave 4.
